ehgu_wrr_arbiter: RTL and testbench



---
 rtl/ehgu_wrr_arbiter.sv | 126 ++++++++++++
 tb/tb_ehgu_wrr_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ehgu_wrr_arbiter.sv
// Weighted round-robin arbiter: one requester at a time owns the shared datapath
// port for up to its programmed weight of accepted beats, then priority rotates.
module ehgu_wrr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int DP_WIDTH     = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DP_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*WEIGHT_WIDTH-1:0] weight,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            out_valid,
    output logic [DP_WIDTH-1:0]             out_data,
    output logic [$clog2(NUM_REQ)-1:0]      out_src,
    input  logic                            out_ready,
    output logic                            busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [WEIGHT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [WEIGHT_WIDTH-1:0] wlim_q, wlim_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;

    logic [IDX_W-1:0]        sel;
    logic                    sel_found;
    logic [WEIGHT_WIDTH-1:0] sel_weight;
    logic [WEIGHT_WIDTH:0]   cnt_inc;
    logic                    accept;
    logic                    tenure_end;

    // Rotating search: first requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!sel_found && req[idx]) begin
                sel       = IDX_W'(idx);
                sel_found = 1'b1;
            end
        end
    end

    assign sel_weight = weight[sel*WEIGHT_WIDTH +: WEIGHT_WIDTH];

    assign busy      = (state_q == GRANT);
    assign gnt       = gnt_q;
    assign out_valid = busy & req[owner_q];
    assign out_src   = busy ? owner_q : '0;
    assign out_data  = busy ? req_data[owner_q*DP_WIDTH +: DP_WIDTH] : '0;

    assign accept  = out_valid & out_ready;
    assign cnt_inc = {1'b0, beat_cnt_q} + 1'b1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        wlim_d     = wlim_q;
        gnt_d      = gnt_q;
        tenure_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d    = GRANT;
                    owner_d    = sel;
                    gnt_d      = NUM_REQ'(1) << sel;
                    beat_cnt_d = '0;
                    wlim_d     = (sel_weight == '0) ? WEIGHT_WIDTH'(1) : sel_weight;
                end
            end
            GRANT: begin
                // A dropped request ends the tenure even with no beat accepted.
                if (!req[owner_q]) begin
                    tenure_end = 1'b1;
                end else if (accept) begin
                    if (cnt_inc == {1'b0, wlim_q}) tenure_end = 1'b1;
                    else if (beat_cnt_q != '1)     beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (tenure_end) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            wlim_q     <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            wlim_q     <= wlim_d;
            gnt_q      <= gnt_d;
        end
    end

endmodule

// File: tb/tb_ehgu_wrr_arbiter.sv
// Self-checking bench for ehgu_wrr_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural model.
module tb_ehgu_wrr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    gnt;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_ready;
    logic            busy;

    int checks = 0;
    int errors = 0;

    ehgu_wrr_arbiter #(.NUM_REQ(N), .WEIGHT_WIDTH(WW), .DP_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .weight(weight),
        .gnt(gnt), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [15:0]  weight;
        logic         ready;
        logic [N-1:0] gnt;
        logic         valid;
        logic [1:0]   src;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [15:0] w,
                       input logic rdy, input logic [3:0] g, input logic v, input logic [1:0] s);
        vec_t x;
        x.rst = r; x.req = rq; x.weight = w; x.ready = rdy;
        x.gnt = g; x.valid = v; x.src = s;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fixed data pattern used by the directed parts: requester i drives 16'hA000+i.
    localparam logic [N*DW-1:0] PAT = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    // Inputs are already applied; check at the falling edge, then advance past the next rising edge.
    task automatic step_check(input string tag, input logic [3:0] g, input logic v, input logic [1:0] s);
        logic [15:0] d;
        @(negedge clk);
        d = (g != 0) ? PAT[s*DW +: DW] : 16'h0;
        check({tag, ".gnt"},   32'(gnt),       32'(g));
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".src"},   32'(out_src),   32'(s));
        check({tag, ".busy"},  32'(busy),      32'(g != 0));
        check({tag, ".data"},  32'(out_data),  32'(d));
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: who owns the port, how many beats taken, where the search starts.
    bit m_busy;
    int m_owner, m_beats, m_lim, m_ptr;

    task automatic model_update();
        int w, i;
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (req[i]) begin
                    w       = int'(weight[i*WW +: WW]);
                    m_busy  = 1;
                    m_owner = i;
                    m_beats = 0;
                    m_lim   = (w == 0) ? 1 : w;
                    break;
                end
            end
        end else if (!req[m_owner] || (out_ready && (m_beats + 1 == m_lim))) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
        end else if (out_ready) begin
            m_beats++;
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = PAT; weight = '0; out_ready = 1'b1;
        #1;
        check("reset.gnt",   32'(gnt),       32'h0);
        check("reset.busy",  32'(busy),      32'h0);
        check("reset.valid", 32'(out_valid), 32'h0);
        check("reset.src",   32'(out_src),   32'h0);
        check("reset.data",  32'(out_data),  32'h0);

        // Single requester, weight 3: three beats, bubble, regrant.
        add(1, 4'b0000, 16'h0003, 1, 4'b0000, 0, 0);
        add(0, 4'b0001, 16'h0003, 1, 4'b0000, 0, 0);
        add(0, 4'b0001, 16'h0003, 1, 4'b0001, 1, 0);
        add(0, 4'b0001, 16'h0003, 1, 4'b0001, 1, 0);
        add(0, 4'b0001, 16'h0003, 1, 4'b0001, 1, 0);
        add(0, 4'b0001, 16'h0003, 1, 4'b0000, 0, 0);
        add(0, 4'b0001, 16'h0003, 1, 4'b0001, 1, 0);
        // req 0101, weights 2 and 1: src 0,0,-,2,-,0,0,-,2.
        add(1, 4'b0101, 16'h0102, 1, 4'b0000, 0, 0);
        add(0, 4'b0101, 16'h0102, 1, 4'b0000, 0, 0);
        add(0, 4'b0101, 16'h0102, 1, 4'b0001, 1, 0);
        add(0, 4'b0101, 16'h0102, 1, 4'b0001, 1, 0);
        add(0, 4'b0101, 16'h0102, 1, 4'b0000, 0, 0);
        add(0, 4'b0101, 16'h0102, 1, 4'b0100, 1, 2);
        add(0, 4'b0101, 16'h0102, 1, 4'b0000, 0, 0);
        add(0, 4'b0101, 16'h0102, 1, 4'b0001, 1, 0);
        add(0, 4'b0101, 16'h0102, 1, 4'b0001, 1, 0);
        add(0, 4'b0101, 16'h0102, 1, 4'b0000, 0, 0);
        add(0, 4'b0101, 16'h0102, 1, 4'b0100, 1, 2);
        // Weight 2 with out_ready 1,0,0,1: tenure ends only after the second accept.
        add(1, 4'b0001, 16'h0002, 1, 4'b0000, 0, 0);
        add(0, 4'b0001, 16'h0002, 1, 4'b0000, 0, 0);
        add(0, 4'b0001, 16'h0002, 1, 4'b0001, 1, 0);
        add(0, 4'b0001, 16'h0002, 0, 4'b0001, 1, 0);
        add(0, 4'b0001, 16'h0002, 0, 4'b0001, 1, 0);
        add(0, 4'b0001, 16'h0002, 1, 4'b0001, 1, 0);
        add(0, 4'b0001, 16'h0002, 1, 4'b0000, 0, 0);
        // Weight 0 on requester 1 behaves as one beat per tenure.
        add(1, 4'b0010, 16'h5505, 1, 4'b0000, 0, 0);
        add(0, 4'b0010, 16'h5505, 1, 4'b0000, 0, 0);
        add(0, 4'b0010, 16'h5505, 1, 4'b0010, 1, 1);
        add(0, 4'b0010, 16'h5505, 1, 4'b0000, 0, 0);
        add(0, 4'b0010, 16'h5505, 1, 4'b0010, 1, 1);
        add(0, 4'b0010, 16'h5505, 1, 4'b0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; req = vecs[i].req; weight = vecs[i].weight;
            out_ready = vecs[i].ready;
            step_check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].valid, vecs[i].src);
        end

        // Requester 3 (weight 5) drops after two beats; pointer wraps to 0 and 0 wins over 1.
        rst = 1'b1; req = '0; weight = 16'h5000; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b1000;
        step_check("p5_idle", 4'b0000, 0, 0);
        step_check("p5_b1",   4'b1000, 1, 3);
        step_check("p5_b2",   4'b1000, 1, 3);
        req = 4'b0011;
        step_check("p5_drop", 4'b1000, 0, 3);
        step_check("p5_bub",  4'b0000, 0, 0);
        step_check("p5_wrap", 4'b0001, 1, 0);

        // Asynchronous reset mid-tenure, then the first grant searches from index 0.
        rst = 1'b1; req = '0; weight = 16'h0500;
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b0100;
        step_check("p6_idle",  4'b0000, 0, 0);
        step_check("p6_grant", 4'b0100, 1, 2);
        #3 rst = 1'b1;
        #1;
        check("p6_rst.gnt",   32'(gnt),       32'h0);
        check("p6_rst.valid", 32'(out_valid), 32'h0);
        check("p6_rst.busy",  32'(busy),      32'h0);
        check("p6_rst.src",   32'(out_src),   32'h0);
        req = 4'b0110;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        step_check("p6_regrant", 4'b0010, 1, 1);

        // Random traffic against the model, with weights changing every cycle.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_busy = 0; m_owner = 0; m_beats = 0; m_lim = 0; m_ptr = 0;
        for (int n = 0; n < 600; n++) begin
            req       = N'($urandom);
            weight    = {$urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 4'($urandom_range(0, 15))};
            out_ready = ($urandom_range(0, 3) != 0);
            req_data  = {$urandom, $urandom};
            @(negedge clk);
            check($sformatf("rnd%0d.gnt", n),   32'(gnt),       m_busy ? (32'h1 << m_owner) : 32'h0);
            check($sformatf("rnd%0d.valid", n), 32'(out_valid), 32'(m_busy && req[m_owner]));
            check($sformatf("rnd%0d.src", n),   32'(out_src),   m_busy ? 32'(m_owner) : 32'h0);
            check($sformatf("rnd%0d.busy", n),  32'(busy),      32'(m_busy));
            check($sformatf("rnd%0d.data", n),  32'(out_data),  m_busy ? 32'(req_data[m_owner*DW +: DW]) : 32'h0);
            @(posedge clk);
            model_update();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
